freq_meter: RTL and testbench

- Reciprocal of the clock divider chain: the divider turns a known fast clock into slow ticks, and this block measures an unknown slow signal by counting its rising edges over a gate of exactly GATE_CYCLES periods of clk_in (1 s at 50 MHz).
- Used by the clock design to self-check divider outputs and to measure external signals.
- Result is a binary edge count, i.e. Hz when the gate is 1 s.

---
 rtl/freq_meter.sv | 117 +++++++++++
 tb/tb_freq_meter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/freq_meter.sv
// Gated edge counter: counts rising edges of an asynchronous signal over a gate of
// exactly GATE_CYCLES clk_in cycles and reports the (saturated) count with a valid pulse.
module freq_meter #(
  parameter int GATE_CYCLES = 50000000,
  parameter int GATE_W      = 26,
  parameter int CNT_W       = 27
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic             start,
  input  logic             cont_en,
  output logic             busy,
  output logic             valid,
  output logic [CNT_W-1:0] freq_out,
  output logic             ovf
);

  typedef enum logic [0:0] {IDLE, GATE} state_t;

  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

  state_t            state, state_nxt;
  logic              s1, s2, s3;
  logic              edge_det;
  logic [GATE_W-1:0] gate_cnt, gate_cnt_nxt;
  logic [CNT_W-1:0]  edge_cnt, edge_cnt_nxt;
  logic              sat, sat_nxt;
  logic              valid_nxt;
  logic [CNT_W-1:0]  freq_nxt;
  logic              ovf_nxt;
  logic              at_max;
  logic              sat_hit;
  logic              last_cycle;
  logic [CNT_W-1:0]  edge_sum;

  // Two-flop synchronizer plus a history flop for rising-edge detection.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign edge_det   = s2 & ~s3;
  assign at_max     = (edge_cnt == CNT_MAX);
  assign sat_hit    = edge_det & at_max;
  assign edge_sum   = (edge_det && !at_max) ? edge_cnt + CNT_W'(1) : edge_cnt;
  assign last_cycle = (gate_cnt == GATE_LAST);
  assign busy       = (state == GATE);

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gate_cnt <= '0;
      edge_cnt <= '0;
      sat      <= 1'b0;
      valid    <= 1'b0;
      freq_out <= '0;
      ovf      <= 1'b0;
    end else begin
      state    <= state_nxt;
      gate_cnt <= gate_cnt_nxt;
      edge_cnt <= edge_cnt_nxt;
      sat      <= sat_nxt;
      valid    <= valid_nxt;
      freq_out <= freq_nxt;
      ovf      <= ovf_nxt;
    end
  end

  // A start coinciding with the valid pulse is dropped; cont_en re-arms regardless.
  always_comb begin
    state_nxt    = state;
    gate_cnt_nxt = gate_cnt;
    edge_cnt_nxt = edge_cnt;
    sat_nxt      = sat;
    valid_nxt    = 1'b0;
    freq_nxt     = freq_out;
    ovf_nxt      = ovf;
    case (state)
      IDLE: begin
        if (cont_en || (start && !valid)) begin
          state_nxt    = GATE;
          gate_cnt_nxt = '0;
          edge_cnt_nxt = '0;
          sat_nxt      = 1'b0;
        end
      end
      GATE: begin
        if (last_cycle) begin
          valid_nxt    = 1'b1;
          freq_nxt     = edge_sum;
          ovf_nxt      = sat | sat_hit;
          gate_cnt_nxt = '0;
          edge_cnt_nxt = '0;
          sat_nxt      = 1'b0;
          if (!cont_en) begin
            state_nxt = IDLE;
          end
        end else begin
          gate_cnt_nxt = gate_cnt + GATE_W'(1);
          edge_cnt_nxt = edge_sum;
          sat_nxt      = sat | sat_hit;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_freq_meter.sv
// Randomized self-checking bench for freq_meter: a level generator logs every rising
// edge it drives, and expected counts come from counting logged edges inside each gate window.
module tb_freq_meter;

  localparam int G    = 100;
  localparam int CW   = 4;
  localparam int MAXV = (1 << CW) - 1;

  logic          clk_in = 1'b0;
  logic          rst_n;
  logic          sig_in;
  logic          start;
  logic          cont_en;
  logic          busy;
  logic          valid;
  logic [CW-1:0] freq_out;
  logic          ovf;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  bit gen_on = 1'b0;
  int hi_w   = 5;
  int lo_w   = 5;
  int rise_q[$];

  freq_meter #(.GATE_CYCLES(G), .GATE_W(7), .CNT_W(CW)) dut (
    .clk_in  (clk_in),
    .rst_n   (rst_n),
    .sig_in  (sig_in),
    .start   (start),
    .cont_en (cont_en),
    .busy    (busy),
    .valid   (valid),
    .freq_out(freq_out),
    .ovf     (ovf)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc <= cyc + 1;

  // Pattern generator: hi_w/lo_w are latched at the start of each period.
  initial begin
    int phase;
    int cur_hi;
    int cur_lo;
    phase  = 0;
    cur_hi = 5;
    cur_lo = 5;
    sig_in = 1'b0;
    forever begin
      @(posedge clk_in);
      #1;
      if (!gen_on) begin
        sig_in = 1'b0;
        phase  = 0;
      end else begin
        if (phase == 0) begin
          cur_hi = hi_w;
          cur_lo = lo_w;
        end
        if (phase < cur_hi) begin
          if (!sig_in) rise_q.push_back(cyc);
          sig_in = 1'b1;
        end else begin
          sig_in = 1'b0;
        end
        phase = (phase + 1 >= cur_hi + cur_lo) ? 0 : phase + 1;
      end
    end
  end

  function automatic int modelEdges(input int lo_c, input int hi_c);
    int n;
    n = 0;
    foreach (rise_q[i]) if (rise_q[i] >= lo_c && rise_q[i] <= hi_c) n++;
    return n;
  endfunction

  function automatic int satCount(input int n);
    return (n > MAXV) ? MAXV : n;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input bit cont, output int c_s);
    @(posedge clk_in);
    #1;
    if (cont) cont_en = 1'b1;
    else      start   = 1'b1;
    c_s = cyc;
    @(posedge clk_in);
    #1;
    start = 1'b0;
  endtask

  task automatic waitValid(input int limit, input int inject_at, output int vcyc, output int busy_n);
    vcyc   = -1;
    busy_n = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk_in);
      if (i == inject_at)     start = 1'b1;
      if (i == inject_at + 1) start = 1'b0;
      if (busy) busy_n++;
      if (valid) begin
        vcyc = cyc;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic runSingle(input string tag, input int inject_at);
    int c_s, vcyc, bn, n;
    applyStimulus(1'b0, c_s);
    waitValid(G + 20, inject_at, vcyc, bn);
    n = modelEdges(c_s - 1, c_s + G - 2);
    checkOutput({tag, "_latency"}, vcyc - c_s, G + 1);
    checkOutput({tag, "_busy_cycles"}, bn, G);
    checkOutput({tag, "_freq"}, 32'(freq_out), satCount(n));
    checkOutput({tag, "_ovf"}, 32'(ovf), 32'(n > MAXV));
    checkOutput({tag, "_busy_at_valid"}, 32'(busy), 0);
    @(negedge clk_in);
    checkOutput({tag, "_valid_width"}, 32'(valid), 0);
  endtask

  initial begin
    int c_s, vcyc, bn, n, dut_sum, model_sum;
    rst_n   = 1'b0;
    start   = 1'b0;
    cont_en = 1'b0;
    #23;
    checkOutput("reset_busy", 32'(busy), 0);
    checkOutput("reset_valid", 32'(valid), 0);
    checkOutput("reset_freq", 32'(freq_out), 0);
    checkOutput("reset_ovf", 32'(ovf), 0);
    @(posedge clk_in);
    #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk_in);

    $display("[TB] period 10 single gate");
    hi_w = 5; lo_w = 5; gen_on = 1'b1;
    repeat ($urandom_range(3, 12)) @(posedge clk_in);
    runSingle("p10", -1);

    $display("[TB] idle signal");
    gen_on = 1'b0;
    repeat (6) @(posedge clk_in);
    runSingle("zero", -1);

    $display("[TB] saturation then recovery");
    hi_w = 2; lo_w = 2; gen_on = 1'b1;
    repeat ($urandom_range(3, 9)) @(posedge clk_in);
    runSingle("sat", -1);
    hi_w = 10; lo_w = 10;
    repeat (25) @(posedge clk_in);
    runSingle("p20", -1);

    $display("[TB] start mid-gate ignored");
    hi_w = 5; lo_w = 5;
    repeat (12) @(posedge clk_in);
    runSingle("midstart", 50);
    waitValid(G + 20, -1, vcyc, bn);
    checkOutput("midstart_no_second_valid", 32'(vcyc == -1), 1);
    checkOutput("midstart_idle", bn, 0);

    $display("[TB] continuous mode");
    applyStimulus(1'b1, c_s);
    dut_sum   = 0;
    model_sum = 0;
    for (int k = 1; k <= 5; k++) begin
      waitValid(G + 20, -1, vcyc, bn);
      n = modelEdges(c_s - 1 + (k - 1) * G, c_s - 2 + k * G);
      dut_sum   += int'(freq_out);
      model_sum += satCount(n);
      checkOutput($sformatf("cont%0d_latency", k), vcyc - c_s, 1 + k * G);
      checkOutput($sformatf("cont%0d_freq", k), 32'(freq_out), satCount(n));
      checkOutput($sformatf("cont%0d_busy", k), 32'(busy), 32'(k < 5));
      @(negedge clk_in);
      checkOutput($sformatf("cont%0d_valid_width", k), 32'(valid), 0);
      if (k == 3) begin
        hi_w = 10; lo_w = 10;
      end
      if (k == 4) cont_en = 1'b0;
    end
    checkOutput("cont_sum", dut_sum, model_sum);
    checkOutput("cont_last_is_5", 32'(freq_out), 5);

    $display("[TB] reset mid-gate");
    repeat (5) @(posedge clk_in);
    applyStimulus(1'b0, c_s);
    repeat (40) @(posedge clk_in);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_reset_busy", 32'(busy), 0);
    checkOutput("mid_reset_valid", 32'(valid), 0);
    checkOutput("mid_reset_freq", 32'(freq_out), 0);
    checkOutput("mid_reset_ovf", 32'(ovf), 0);
    repeat (2) @(posedge clk_in);
    #1;
    rst_n = 1'b1;
    waitValid(G + 20, -1, vcyc, bn);
    checkOutput("no_valid_after_reset", 32'(vcyc == -1), 1);
    repeat (20) @(posedge clk_in);
    runSingle("post_reset", -1);

    $display("[TB] random periods");
    for (int r = 0; r < 4; r++) begin
      hi_w = $urandom_range(2, 9);
      lo_w = $urandom_range(2, 9);
      repeat ($urandom_range(20, 40)) @(posedge clk_in);
      runSingle($sformatf("rand%0d", r), -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
